// File: rtl/bp_be_idiv_seq.sv
// Sequential restoring radix-2 integer divider, one quotient bit per cycle,
// with signed/unsigned operands and fixed width_p+2 cycle latency.
module bp_be_idiv_seq #(
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_div_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int unsigned cnt_w_lp = $clog2(width_p);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(width_p - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e              state_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic [width_p:0]    rem_q;
  logic [width_p-1:0]  quo_q;
  logic [width_p-1:0]  dvs_q;
  logic [width_p-1:0]  dend_orig_q;
  logic                signed_q, dend_neg_q, dvs_neg_q, dvs_zero_q;

  logic                dend_neg, dvs_neg, ge;
  logic [width_p-1:0]  dend_abs, dvs_abs;
  logic [width_p:0]    rem_shift, rem_diff;

  always_comb begin
    dend_neg  = signed_div_i & dividend_i[width_p-1];
    dvs_neg   = signed_div_i & divisor_i[width_p-1];
    dend_abs  = dend_neg ? -dividend_i : dividend_i;
    dvs_abs   = dvs_neg ? -divisor_i : divisor_i;
    // Dividend bits shift out of the quotient register into the partial remainder.
    rem_shift = {rem_q[width_p-1:0], quo_q[width_p-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    // A set top bit means the partial remainder already exceeds any divisor.
    ge        = (rem_shift >= {1'b0, dvs_q}) | rem_q[width_p];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dend_orig_q <= '0;
      signed_q    <= 1'b0;
      dend_neg_q  <= 1'b0;
      dvs_neg_q   <= 1'b0;
      dvs_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (v_i) begin
            state_q     <= StCalc;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= dend_abs;
            dvs_q       <= dvs_abs;
            dend_orig_q <= dividend_i;
            signed_q    <= signed_div_i;
            dend_neg_q  <= dend_neg;
            dvs_neg_q   <= dvs_neg;
            dvs_zero_q  <= (divisor_i == '0);
          end
        end
        StCalc: begin
          rem_q <= ge ? rem_diff : rem_shift;
          quo_q <= {quo_q[width_p-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == cnt_last_lp) begin
            state_q <= StSign;
          end
        end
        StSign: begin
          state_q <= StDone;
          if (dvs_zero_q) begin
            quo_q <= '1;
            rem_q <= {1'b0, dend_orig_q};
          end else if (signed_q) begin
            if (dend_neg_q ^ dvs_neg_q) begin
              quo_q <= -quo_q;
            end
            if (dend_neg_q) begin
              rem_q <= {1'b0, -rem_q[width_p-1:0]};
            end
          end
        end
        StDone: begin
          if (yumi_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o     = (state_q == StIdle);
  assign v_o         = (state_q == StDone);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[width_p-1:0];

endmodule

// File: tb/tb_bp_be_idiv_seq.sv
// Directed self-checking bench for bp_be_idiv_seq at width_p = 64.
module tb_bp_be_idiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] dividend, divisor;
  logic        signed_div, v_i, yumi;
  logic        ready, v_o;
  logic [63:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_be_idiv_seq #(.width_p(64)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .signed_div_i(signed_div),
    .v_i         (v_i),
    .ready_o     (ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .v_o         (v_o),
    .yumi_i      (yumi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the accept edge; waits for v_o, checks, consumes.
  task automatic wait_result(input string tag, input logic [63:0] eq, input logic [63:0] er);
    int n;
    n = 1;
    chk({tag, "_busy"}, {63'b0, ready}, 64'd0);
    while (!v_o && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(n), 64'd66);
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
    chk({tag, "_ready_after"}, {62'b0, ready, v_o}, 64'b10);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [63:0] eq, input logic [63:0] er);
    @(negedge clk);
    chk({tag, "_ready"}, {63'b0, ready}, 64'd1);
    dividend   = a;
    divisor    = b;
    signed_div = s;
    v_i        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    wait_result(tag, eq, er);
  endtask

  initial begin
    reset = 1'b1; v_i = 1'b0; yumi = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_v_o", {63'b0, v_o}, 64'd0);
    chk("rst_quo", quotient, 64'd0);
    chk("rst_rem", remainder, 64'd0);
    reset = 1'b0;

    run_op("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2);
    run_op("s-7_2", -64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1);
    run_op("s7_-2", 64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1);
    run_op("s_div0", 64'h1234, 64'd0, 1'b1, '1, 64'h1234);
    run_op("u_div0", 64'h1234, 64'd0, 1'b0, '1, 64'h1234);
    run_op("s-5_div0", -64'sd5, 64'd0, 1'b1, '1, -64'sd5);
    run_op("s_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 64'd0);
    run_op("u_ovf", 64'h8000_0000_0000_0000, '1, 1'b0, 64'd0, 64'h8000_0000_0000_0000);
    run_op("u_big", '1, 64'h10, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF);

    // Backpressure: hold result 10 cycles while a new request is offered.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; signed_div = 1'b0; v_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 64'd50; divisor = 64'd5;
    begin
      int n;
      n = 1;
      while (!v_o && n < 200) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      chk("bp_latency", 64'(n), 64'd66);
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {quotient[31:0], remainder[29:0], ready, v_o}, {32'd14, 30'd2, 1'b0, 1'b1});
      @(posedge clk);
      @(negedge clk);
    end
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
    chk("bp_idle", {62'b0, ready, v_o}, 64'b10);
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    wait_result("bp_next", 64'd10, 64'd0);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; signed_div = 1'b0; v_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {63'b0, ready}, 64'd0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_state", {62'b0, ready, v_o}, 64'b10);
    chk("mid_rst_quo", quotient, 64'd0);
    chk("mid_rst_rem", remainder, 64'd0);
    #1 reset = 1'b0;
    run_op("after_rst", 64'd9, 64'd3, 1'b0, 64'd3, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
